ped_crossing_ctrl: RTL and testbench
====================================

PED_CROSSING_CTRL -- requirements
Module: ped_crossing_ctrl

Interface
REQ-001 Parameter WALK_CYCLES, 3, number of clk cycles walk is held high (1..15).
REQ-002 Parameter FLASH_CYCLES, 2, number of clk cycles of flashing clearance (1..15).
REQ-003 Parameter DEBOUNCE, 3, consecutive synchronized-high cycles required to accept a button press (1..15).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 light  input  3  vehicle light from the upstream traffic light controller, one-hot: RED=100, YELLOW=010, GREEN=001.
REQ-007 ped_btn  input  1  asynchronous pedestrian push-button, active-high.
REQ-008 walk  output  1  WALK lamp.
REQ-009 dont_walk  output  1  DON'T WALK lamp; steady or flashing.
REQ-010 req_pending  output  1  accepted request awaiting service.
REQ-011 countdown  output  4  remaining cycles in WALK/CLEAR; 0 otherwise.
REQ-012 fault  output  1  sticky invalid-light-code indicator.

Function
REQ-013 ped_btn shall pass through a 2-flop synchronizer; btn_s is the second flop output.
REQ-014 Debounce counter shall increment while btn_s=1 (saturating at DEBOUNCE) and clear to 0 when btn_s=0; press event = btn_s=1 and counter==DEBOUNCE-1.
REQ-015 With ped_btn held high, req_pending shall rise at the (DEBOUNCE+2)th rising edge after ped_btn is first sampled high; one press event per hold.
REQ-016 light_q shall register light every cycle; red_entry = (light==RED) and (light_q!=RED).
REQ-017 States: IDLE, WALK, CLEAR, FAULT.
REQ-018 IDLE: walk=0, dont_walk=1; on red_entry with (req_pending or press event) go to WALK, load counter WALK_CYCLES-1, clear req_pending.
REQ-019 Requests arriving while light is already RED shall wait for the next red_entry; no mid-red start.
REQ-020 WALK: walk=1, dont_walk=0, countdown=counter; counter decrements each cycle; at counter 0 go to CLEAR, load FLASH_CYCLES-1, blink bit set to 1.
REQ-021 CLEAR: walk=0, dont_walk=blink bit, toggled every cycle starting at 1; countdown=counter; at counter 0 go to IDLE.
REQ-022 If light!=RED while in WALK or CLEAR, next state shall be IDLE (walk=0, dont_walk=1 next cycle) and req_pending shall be set (aborted crossing re-queued).
REQ-023 Press events in WALK or CLEAR shall set req_pending; a press event in the same cycle as WALK entry is absorbed (req_pending stays 0).
REQ-024 If light is not one of the three valid codes in any state, next state shall be FAULT with priority over all other transitions.
REQ-025 FAULT: walk=0, dont_walk=1, fault=1, countdown=0, req_pending=0; exit only by rst.
REQ-026 Counter shall be 4 bits; no wrap-around permitted (loads bounded by parameters).
REQ-027 Outputs shall be decoded only from registered state; no combinational path from light or ped_btn to outputs.

Reset
REQ-028 On rst: state IDLE, walk=0, dont_walk=1, req_pending=0, fault=0, countdown=0, light_q=RED, synchronizer flops and debounce counter 0, blink bit 0.
REQ-029 rst asserted mid-WALK/CLEAR shall drop walk and assert dont_walk immediately (asynchronously); a light already RED when rst deasserts shall not create red_entry.

Verification
REQ-030 ped_btn high 6 cycles while light=GREEN -> req_pending=1 at 5th edge; light goes RED -> walk=1 for 3 cycles, countdown 2,1,0.
REQ-031 After WALK -> CLEAR: dont_walk 1,0 over 2 cycles, countdown 1,0, then IDLE with dont_walk=1, req_pending=0.
REQ-032 Light leaves RED during WALK (cycle 2) -> walk=0, dont_walk=1 next cycle, req_pending=1; served at next RED entry.
REQ-033 ped_btn pulse 2 cycles (shorter than DEBOUNCE) -> req_pending stays 0, no WALK on next RED.
REQ-034 light=011 for one cycle during WALK -> FAULT next cycle: walk=0, dont_walk=1, fault=1, stays until rst.
REQ-035 Press accepted while light already RED -> no walk this red; WALK starts on the following red_entry.

Source files
------------

// File: rtl/ped_crossing_if.sv
// Signal bundle between the pedestrian crossing controller and its environment.
// The master side drives the vehicle light and push-button; the slave side drives the lamps.
interface ped_crossing_if;
    logic [2:0] light;
    logic       ped_btn;
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
    logic [3:0] countdown;
    logic       fault;

    modport master (
        output light,
        output ped_btn,
        input  walk,
        input  dont_walk,
        input  req_pending,
        input  countdown,
        input  fault
    );

    modport slave (
        input  light,
        input  ped_btn,
        output walk,
        output dont_walk,
        output req_pending,
        output countdown,
        output fault
    );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: debounced button requests are served as a WALK / flashing
// CLEAR sequence that starts only when the vehicle light enters RED.
module ped_crossing_ctrl #(
    parameter int unsigned WALK_CYCLES  = 3,
    parameter int unsigned FLASH_CYCLES = 2,
    parameter int unsigned DEBOUNCE     = 3
) (
    input  logic           clk,
    input  logic           rst,
    ped_crossing_if.slave  pif
);

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam logic [3:0] WALK_LOAD  = 4'(WALK_CYCLES - 1);
    localparam logic [3:0] FLASH_LOAD = 4'(FLASH_CYCLES - 1);
    localparam logic [3:0] DEB_MAX    = 4'(DEBOUNCE);
    localparam logic [3:0] DEB_HIT    = 4'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_CLEAR,
        ST_FAULT
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizer and debounce
    // ------------------------------------------------------------------
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic       press;

    always_comb begin
        sync1_d   = pif.ped_btn;
        sync2_d   = sync1_q;
        deb_cnt_d = 4'd0;
        if (sync2_q) begin
            deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + 4'd1;
        end
    end

    // Saturation stops the counter past DEB_HIT, so a held button yields one press only.
    assign press = sync2_q && (deb_cnt_q == DEB_HIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_cnt_q <= 4'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Vehicle light tracking
    // ------------------------------------------------------------------
    logic [2:0] light_q, light_d;
    logic       light_valid;
    logic       is_red;
    logic       red_entry;

    always_comb begin
        light_d = pif.light;
    end

    assign is_red      = (pif.light == LIGHT_RED);
    assign light_valid = (pif.light == LIGHT_RED) || (pif.light == LIGHT_YELLOW) ||
                         (pif.light == LIGHT_GREEN);
    // light_q resets to RED so a light already RED at reset release is not an entry.
    assign red_entry   = is_red && (light_q != LIGHT_RED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            light_q <= LIGHT_RED;
        end else begin
            light_q <= light_d;
        end
    end

    // ------------------------------------------------------------------
    // Crossing FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       blink_q, blink_d;
    logic       req_q, req_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            blink_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        req_d   = req_q;

        if (!light_valid || (state_q == ST_FAULT)) begin
            // An illegal light code locks the controller up until reset.
            state_d = ST_FAULT;
            cnt_d   = 4'd0;
            blink_d = 1'b0;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (red_entry && (req_q || press)) begin
                        state_d = ST_WALK;
                        cnt_d   = WALK_LOAD;
                        req_d   = 1'b0;
                    end else if (press) begin
                        req_d = 1'b1;
                    end
                end

                ST_WALK: begin
                    if (!is_red) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                        req_d   = 1'b1;
                    end else begin
                        if (press) begin
                            req_d = 1'b1;
                        end
                        if (cnt_q == 4'd0) begin
                            state_d = ST_CLEAR;
                            cnt_d   = FLASH_LOAD;
                            blink_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end

                ST_CLEAR: begin
                    if (!is_red) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                        blink_d = 1'b0;
                        req_d   = 1'b1;
                    end else begin
                        if (press) begin
                            req_d = 1'b1;
                        end
                        if (cnt_q == 4'd0) begin
                            state_d = ST_IDLE;
                            blink_d = 1'b0;
                        end else begin
                            cnt_d   = cnt_q - 4'd1;
                            blink_d = ~blink_q;
                        end
                    end
                end

                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Lamp decode: purely from registered state, so reset acts on the lamps at once.
    // ------------------------------------------------------------------
    logic in_crossing;

    assign in_crossing     = (state_q == ST_WALK) || (state_q == ST_CLEAR);
    assign pif.walk        = (state_q == ST_WALK);
    assign pif.dont_walk   = (state_q == ST_WALK)  ? 1'b0 :
                             (state_q == ST_CLEAR) ? blink_q : 1'b1;
    assign pif.countdown   = in_crossing ? cnt_q : 4'd0;
    assign pif.req_pending = req_q;
    assign pif.fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Randomized and directed bench for ped_crossing_ctrl: a cycle-level reference model fills a
// scoreboard queue at each rising edge and a monitor compares the lamps on each falling edge.
module tb_ped_crossing_ctrl;

    localparam int W = 3;
    localparam int F = 2;
    localparam int D = 3;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] BAD = 3'b011;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ped_crossing_if pif ();

    ped_crossing_ctrl #(
        .WALK_CYCLES  (W),
        .FLASH_CYCLES (F),
        .DEBOUNCE     (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       walk;
        logic       dont_walk;
        logic       req_pending;
        logic [3:0] countdown;
        logic       fault;
    } exp_t;

    exp_t exp_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int walk_seen  = 0;
    int fault_seen = 0;
    int n_popped   = 0;

    // Reference model: crossing tracked as "cycles since the walk began", button as a
    // two-sample delay line feeding a run-length of consecutive highs.
    logic       m_btn_hist[$];
    int         m_run;
    logic [2:0] m_prev_light;
    int         m_cross;
    bit         m_pending;
    bit         m_faulted;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL cycle %0d %s: got %0d expected %0d", cyc, name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_btn_hist.delete();
        m_btn_hist.push_back(1'b0);
        m_btn_hist.push_back(1'b0);
        m_run        = 0;
        m_prev_light = RED;
        m_cross      = -1;
        m_pending    = 1'b0;
        m_faulted    = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] l, input logic b);
        logic bs;
        bit   press;
        bit   valid;
        bit   red_entry;
        bs = m_btn_hist.pop_front();
        m_btn_hist.push_back(b);
        if (bs) m_run = (m_run > D) ? m_run : m_run + 1;
        else    m_run = 0;
        press     = bs && (m_run == D);
        valid     = (l == RED) || (l == YEL) || (l == GRN);
        red_entry = (l == RED) && (m_prev_light != RED);
        m_prev_light = l;

        if (m_faulted || !valid) begin
            m_faulted = 1'b1;
            m_pending = 1'b0;
            m_cross   = -1;
        end else if (m_cross >= 0) begin
            if (l != RED) begin
                m_cross   = -1;
                m_pending = 1'b1;
            end else begin
                m_cross++;
                if (m_cross >= W + F) m_cross = -1;
                if (press) m_pending = 1'b1;
            end
        end else if (red_entry && (m_pending || press)) begin
            m_cross   = 0;
            m_pending = 1'b0;
        end else if (press) begin
            m_pending = 1'b1;
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        int   k;
        e.walk        = 1'b0;
        e.dont_walk   = 1'b1;
        e.req_pending = m_pending;
        e.countdown   = 4'd0;
        e.fault       = m_faulted;
        if (!m_faulted && m_cross >= 0) begin
            if (m_cross < W) begin
                e.walk      = 1'b1;
                e.dont_walk = 1'b0;
                e.countdown = 4'(W - 1 - m_cross);
            end else begin
                k           = m_cross - W;
                e.dont_walk = ((k % 2) == 0);
                e.countdown = 4'(F - 1 - k);
            end
        end
        return e;
    endfunction

    // Model: advances on every rising edge and queues the expected post-edge outputs.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else     model_step(pif.light, pif.ped_btn);
            exp_q.push_back(model_outputs());
        end
    end

    // Monitor: compares the lamps against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_popped++;
                if (pif.walk === 1'b1)  walk_seen++;
                if (pif.fault === 1'b1) fault_seen++;
                check("walk",        int'(pif.walk),        int'(e.walk));
                check("dont_walk",   int'(pif.dont_walk),   int'(e.dont_walk));
                check("req_pending", int'(pif.req_pending), int'(e.req_pending));
                check("countdown",   int'(pif.countdown),   int'(e.countdown));
                check("fault",       int'(pif.fault),       int'(e.fault));
            end
        end
    end

    task automatic drive(input logic [2:0] l, input logic b, input int n);
        repeat (n) begin
            @(negedge clk);
            pif.light   = l;
            pif.ped_btn = b;
        end
    endtask

    task automatic press_on_green();
        drive(GRN, 1'b0, 2);
        drive(GRN, 1'b1, 6);
        drive(GRN, 1'b0, 1);
    endtask

    initial begin
        logic [2:0] rl;
        logic       rb;
        int         len;

        pif.light   = RED;
        pif.ped_btn = 1'b0;

        // Reset held, released with the light already RED: no crossing may start.
        drive(RED, 1'b0, 3);
        @(negedge clk);
        rst = 1'b0;
        drive(RED, 1'b0, 4);

        // Request on GREEN, then a full walk and flashing clearance.
        press_on_green();
        drive(YEL, 1'b0, 2);
        drive(RED, 1'b0, 10);

        // Light leaves RED in the second walk cycle: crossing aborted and re-queued.
        press_on_green();
        drive(RED, 1'b0, 2);
        drive(GRN, 1'b0, 3);
        drive(YEL, 1'b0, 1);
        drive(RED, 1'b0, 8);

        // Short pulse below the debounce length.
        drive(GRN, 1'b1, 2);
        drive(GRN, 1'b0, 4);
        drive(YEL, 1'b0, 1);
        drive(RED, 1'b0, 6);

        // Press event landing exactly on the red entry is absorbed.
        drive(GRN, 1'b1, 4);
        drive(RED, 1'b1, 4);
        drive(RED, 1'b0, 6);
        drive(GRN, 1'b0, 2);

        // Press during the crossing is queued for the next red.
        press_on_green();
        drive(RED, 1'b0, 1);
        drive(RED, 1'b1, 7);
        drive(GRN, 1'b0, 2);
        drive(RED, 1'b0, 8);

        // Press accepted mid-red waits for the following red entry.
        drive(RED, 1'b0, 2);
        drive(RED, 1'b1, 6);
        drive(RED, 1'b0, 3);
        drive(GRN, 1'b0, 2);
        drive(RED, 1'b0, 8);

        // Asynchronous reset in the middle of WALK.
        press_on_green();
        drive(RED, 1'b0, 2);
        @(negedge clk);
        check("pre_rst_walk", int'(pif.walk), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_walk",      int'(pif.walk),      0);
        check("async_rst_dont_walk", int'(pif.dont_walk), 1);
        check("async_rst_countdown", int'(pif.countdown), 0);
        drive(RED, 1'b0, 2);
        @(negedge clk);
        rst = 1'b0;
        drive(RED, 1'b0, 3);

        // Random light sequences with a randomly toggling button.
        rb = 1'b0;
        repeat (60) begin
            case ($urandom_range(0, 2))
                0:       rl = GRN;
                1:       rl = YEL;
                default: rl = RED;
            endcase
            len = int'($urandom_range(1, 10));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) rb = ~rb;
                drive(rl, rb, 1);
            end
        end
        drive(GRN, 1'b0, 3);

        // Illegal code during WALK: sticky fault that survives valid lights and presses.
        press_on_green();
        drive(RED, 1'b0, 2);
        drive(BAD, 1'b0, 1);
        drive(RED, 1'b0, 4);
        drive(GRN, 1'b1, 6);
        drive(RED, 1'b0, 3);

        // Only reset clears the fault.
        @(negedge clk);
        rst = 1'b1;
        drive(RED, 1'b0, 2);
        @(negedge clk);
        rst = 1'b0;
        drive(RED, 1'b0, 2);
        drive(GRN, 1'b0, 3);

        check("walk_observed",  int'(walk_seen > 0), 1);
        check("fault_observed", int'(fault_seen > 0), 1);
        check("monitor_active", int'(n_popped > 200), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
